// File: rtl/ram_port_arbiter.sv
// Two-master arbiter in front of the single-port SRAM wrapper.
// Ports: instr_* fetch master, data_* load/store master,
//        ram_* request side to the SRAM (1-cycle read latency).
module ram_port_arbiter #(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        instr_req,
   input  logic [31:0] instr_addr,
   output logic        instr_gnt,
   output logic        instr_rvalid,
   output logic [31:0] instr_rdata,
   input  logic        data_req,
   input  logic [31:0] data_addr,
   input  logic        data_we,
   input  logic [3:0]  data_be,
   input  logic [31:0] data_wdata,
   output logic        data_gnt,
   output logic        data_rvalid,
   output logic [31:0] data_rdata,
   output logic        ram_req,
   output logic [31:0] ram_addr,
   output logic        ram_we,
   output logic [3:0]  ram_be,
   output logic [31:0] ram_wdata,
   input  logic [31:0] ram_rdata
);

   typedef enum logic [1:0] {
      OWN_NONE,
      OWN_INSTR,
      OWN_DATA_RD,
      OWN_DATA_WR
   } owner_e;

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   owner_e     resp_owner;
   owner_e     owner_d;
   logic [3:0] starve_cnt;
   logic [3:0] starve_d;
   logic       instr_forced;

   // Data wins a contested cycle unless instr has already lost LIMIT times.
   assign instr_forced = (starve_cnt == LIMIT);
   assign instr_gnt    = instr_req & (~data_req | instr_forced);
   assign data_gnt     = data_req & ~instr_gnt;

   // Grants follow inputs during reset, only the RAM strobe is gated.
   assign ram_req = (instr_gnt | data_gnt) & rst_n;

   always_comb begin
      ram_addr  = '0;
      ram_we    = 1'b0;
      ram_be    = '0;
      ram_wdata = '0;
      if (instr_gnt) begin
         ram_addr = instr_addr;
         ram_be   = 4'hF;
      end else if (data_gnt) begin
         ram_addr  = data_addr;
         ram_we    = data_we;
         ram_be    = data_be;
         ram_wdata = data_wdata;
      end
   end

   always_comb begin
      owner_d = OWN_NONE;
      if (instr_gnt) begin
         owner_d = OWN_INSTR;
      end else if (data_gnt) begin
         owner_d = data_we ? OWN_DATA_WR : OWN_DATA_RD;
      end
   end

   always_comb begin
      starve_d = starve_cnt;
      if (!instr_req || instr_gnt) begin
         starve_d = '0;
      end else if (data_gnt && !instr_forced) begin
         starve_d = starve_cnt + 4'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         resp_owner <= OWN_NONE;
         starve_cnt <= '0;
      end else begin
         resp_owner <= owner_d;
         starve_cnt <= starve_d;
      end
   end

   assign instr_rvalid = (resp_owner == OWN_INSTR);
   assign instr_rdata  = instr_rvalid ? ram_rdata : '0;
   assign data_rvalid  = (resp_owner == OWN_DATA_RD) |
                         (resp_owner == OWN_DATA_WR);
   assign data_rdata   = (resp_owner == OWN_DATA_RD) ? ram_rdata : '0;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: behavioural SRAM, golden memory
// and a transaction-level arbitration/response model.
module tb_ram_port_arbiter;

   localparam int LIM = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ireq;
   logic [31:0] iaddr;
   logic        instr_gnt;
   logic        instr_rvalid;
   logic [31:0] instr_rdata;
   logic        dreq;
   logic [31:0] daddr;
   logic        dwe;
   logic [3:0]  dbe;
   logic [31:0] dwdata;
   logic        data_gnt;
   logic        data_rvalid;
   logic [31:0] data_rdata;
   logic        ram_req;
   logic [31:0] ram_addr;
   logic        ram_we;
   logic [3:0]  ram_be;
   logic [31:0] ram_wdata;
   logic [31:0] ram_rdata;

   int errors = 0;
   int checks = 0;

   ram_port_arbiter #(.STARVE_LIMIT(LIM)) dut (
      .clk(clk), .rst_n(rst_n),
      .instr_req(ireq), .instr_addr(iaddr),
      .instr_gnt(instr_gnt), .instr_rvalid(instr_rvalid),
      .instr_rdata(instr_rdata),
      .data_req(dreq), .data_addr(daddr), .data_we(dwe),
      .data_be(dbe), .data_wdata(dwdata),
      .data_gnt(data_gnt), .data_rvalid(data_rvalid),
      .data_rdata(data_rdata),
      .ram_req(ram_req), .ram_addr(ram_addr), .ram_we(ram_we),
      .ram_be(ram_be), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
   );

   always #5 clk = ~clk;

   // Behavioural SRAM: registered read of the pre-write word.
   logic [31:0] mem [0:255];
   always @(posedge clk) begin
      if (ram_req) begin
         ram_rdata <= mem[ram_addr[9:2]];
         if (ram_we) begin
            for (int b = 0; b < 4; b++)
               if (ram_be[b]) mem[ram_addr[9:2]][8*b+:8] = ram_wdata[8*b+:8];
         end
      end
   end

   // Reference model state.
   logic [31:0] gold [0:255];
   int          blocked;
   logic        exp_iv, exp_dv;
   logic [31:0] exp_ir, exp_dr;

   function automatic logic pred_ig();
      return ireq && (!dreq || blocked == LIM);
   endfunction

   task automatic model_clear();
      blocked = 0;
      exp_iv = 1'b0; exp_dv = 1'b0;
      exp_ir = '0;   exp_dr = '0;
   endtask

   // Apply this cycle's transaction to the model (called before the edge).
   task automatic commit();
      logic ig, dg;
      ig = pred_ig();
      dg = dreq && !ig;
      exp_iv = ig; exp_ir = ig ? gold[iaddr[9:2]] : '0;
      exp_dv = dg; exp_dr = '0;
      if (dg && !dwe) exp_dr = gold[daddr[9:2]];
      if (dg && dwe)
         for (int b = 0; b < 4; b++)
            if (dbe[b]) gold[daddr[9:2]][8*b+:8] = dwdata[8*b+:8];
      if (!ireq || ig) blocked = 0;
      else if (blocked < LIM) blocked++;
   endtask

   task automatic idle();
      ireq = 0; iaddr = '0; dreq = 0; daddr = '0;
      dwe = 0; dbe = '0; dwdata = '0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      ireq = 1; iaddr = 32'h40; dreq = 1; daddr = 32'h80;
      @(negedge clk);
      checks++;
      if ({ram_req, instr_rvalid, data_rvalid} !== 3'b000) begin
         errors++;
         $display("FAIL reset_outs req/irv/drv=%b want 000",
                  {ram_req, instr_rvalid, data_rvalid});
      end
      checks++;
      if ({instr_rdata, data_rdata} !== 64'h0) begin
         errors++;
         $display("FAIL reset_rdata got %h want 0", {instr_rdata, data_rdata});
      end
      rst_n = 1'b1;
      #1;
      checks++;
      if ({data_gnt, instr_gnt, ram_req} !== 3'b101) begin
         errors++;
         $display("FAIL reset_first_gnt dg/ig/req=%b want 101",
                  {data_gnt, instr_gnt, ram_req});
      end
      commit();
      @(posedge clk); #1;
      idle();
      @(negedge clk);
      checks++;
      if ({data_rvalid, data_rdata, instr_rvalid} !== {1'b1, gold[32], 1'b0}) begin
         errors++;
         $display("FAIL reset_first_resp got %b/%h/%b want 1/%h/0",
                  data_rvalid, data_rdata, instr_rvalid, gold[32]);
      end
      commit();
      @(posedge clk); #1;
   endtask

   task automatic test_single_instr();
      ireq = 1; iaddr = 32'h40;
      @(negedge clk);
      checks++;
      if ({instr_gnt, data_gnt, ram_req, ram_addr, ram_we, ram_be} !==
          {3'b101, 32'h40, 1'b0, 4'hF}) begin
         errors++;
         $display("FAIL instr_gnt gnt=%b addr=%h we=%b be=%h want 1/40/0/f",
                  instr_gnt, ram_addr, ram_we, ram_be);
      end
      commit();
      @(posedge clk); #1;
      idle();
      @(negedge clk);
      checks++;
      if ({instr_rvalid, instr_rdata, data_rvalid} !==
          {1'b1, 32'h1234_5678, 1'b0}) begin
         errors++;
         $display("FAIL instr_resp got %b/%h/%b want 1/12345678/0",
                  instr_rvalid, instr_rdata, data_rvalid);
      end
      commit();
      @(posedge clk); #1;
   endtask

   task automatic test_byte_write();
      dreq = 1; daddr = 32'h100; dwe = 1; dbe = 4'b0010;
      dwdata = 32'hAABB_CCDD;
      @(negedge clk);
      checks++;
      if ({data_gnt, ram_we, ram_be, ram_wdata, ram_addr} !==
          {1'b1, 1'b1, 4'b0010, 32'hAABB_CCDD, 32'h100}) begin
         errors++;
         $display("FAIL wr_req gnt=%b we=%b be=%b wd=%h a=%h",
                  data_gnt, ram_we, ram_be, ram_wdata, ram_addr);
      end
      commit();
      @(posedge clk); #1;
      dwe = 0; dbe = 4'hF; dwdata = '0;
      @(negedge clk);
      checks++;
      if ({data_rvalid, data_rdata, data_gnt} !== {1'b1, 32'h0, 1'b1}) begin
         errors++;
         $display("FAIL wr_resp got rv=%b rd=%h gnt=%b want 1/0/1",
                  data_rvalid, data_rdata, data_gnt);
      end
      commit();
      @(posedge clk); #1;
      idle();
      @(negedge clk);
      checks++;
      if ({data_rvalid, data_rdata} !== {1'b1, 32'h0000_CC00}) begin
         errors++;
         $display("FAIL rd_after_wr got %b/%h want 1/0000cc00",
                  data_rvalid, data_rdata);
      end
      commit();
      @(posedge clk); #1;
   endtask

   task automatic test_contention();
      ireq = 1; iaddr = 32'h40;
      for (int c = 0; c < 8; c++) begin
         dreq = 1; dwe = 0; dbe = 4'hF; daddr = 32'h200 + 32'(4 * c);
         @(negedge clk);
         checks++;
         if ({instr_gnt, data_gnt} !== {c == LIM, c != LIM}) begin
            errors++;
            $display("FAIL contend_c%0d ig/dg=%b%b want %b%b", c,
                     instr_gnt, data_gnt, c == LIM, c != LIM);
         end
         checks++;
         if ({instr_rvalid, instr_rdata, data_rvalid, data_rdata} !==
             {exp_iv, exp_ir, exp_dv, exp_dr}) begin
            errors++;
            $display("FAIL contend_resp_c%0d got %b/%h %b/%h want %b/%h %b/%h",
                     c, instr_rvalid, instr_rdata, data_rvalid, data_rdata,
                     exp_iv, exp_ir, exp_dv, exp_dr);
         end
         commit();
         @(posedge clk); #1;
      end
      idle();
      @(negedge clk);
      commit();
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      logic        is_i [3];
      logic [31:0] adr  [3];
      is_i = '{1'b1, 1'b0, 1'b1};
      adr  = '{32'h40, 32'h104, 32'h44};
      for (int c = 0; c < 4; c++) begin
         idle();
         if (c < 3) begin
            ireq = is_i[c]; iaddr = adr[c];
            dreq = !is_i[c]; daddr = adr[c]; dbe = 4'hF;
         end
         @(negedge clk);
         if (c < 3) begin
            checks++;
            if ({instr_gnt, data_gnt} !== {is_i[c], !is_i[c]}) begin
               errors++;
               $display("FAIL b2b_gnt_c%0d ig/dg=%b%b", c, instr_gnt, data_gnt);
            end
         end
         if (c > 0) begin
            checks++;
            if ({instr_rvalid, instr_rdata, data_rvalid, data_rdata} !==
                {exp_iv, exp_ir, exp_dv, exp_dr} || !(exp_iv ^ exp_dv)) begin
               errors++;
               $display("FAIL b2b_resp_c%0d got %b/%h %b/%h want %b/%h %b/%h",
                        c, instr_rvalid, instr_rdata, data_rvalid, data_rdata,
                        exp_iv, exp_ir, exp_dv, exp_dr);
            end
         end
         commit();
         @(posedge clk); #1;
      end
   endtask

   task automatic test_midflight_reset();
      ireq = 1; iaddr = 32'h40;
      @(negedge clk);
      checks++;
      if (instr_gnt !== 1'b1) begin
         errors++;
         $display("FAIL mid_gnt got %b want 1", instr_gnt);
      end
      commit();
      @(posedge clk);
      idle();
      #2 rst_n = 1'b0;
      #1;
      model_clear();
      checks++;
      if ({instr_rvalid, instr_rdata, ram_req} !== {1'b0, 32'h0, 1'b0}) begin
         errors++;
         $display("FAIL mid_drop got %b/%h/%b want 0/0/0",
                  instr_rvalid, instr_rdata, ram_req);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      checks++;
      if ({instr_rvalid, data_rvalid} !== 2'b00) begin
         errors++;
         $display("FAIL mid_after got irv/drv=%b want 00",
                  {instr_rvalid, data_rvalid});
      end
   endtask

   task automatic test_random();
      logic ip, dp, ig, dg;
      ip = 0; dp = 0;
      for (int n = 0; n < 400; n++) begin
         if (!ip && $urandom_range(3) != 0) begin
            ip = 1; iaddr = {22'h0, 8'($urandom), 2'b00};
         end else if (ip && $urandom_range(15) == 0) ip = 0;
         if (!dp && $urandom_range(3) != 0) begin
            dp = 1; daddr = {22'h0, 8'($urandom), 2'b00};
            dwe = 1'($urandom); dbe = 4'($urandom); dwdata = $urandom;
         end else if (dp && $urandom_range(15) == 0) dp = 0;
         ireq = ip; dreq = dp;
         @(negedge clk);
         ig = pred_ig();
         dg = dreq && !ig;
         checks++;
         if ({instr_gnt, data_gnt, ram_req} !== {ig, dg, ig | dg}) begin
            errors++;
            $display("FAIL rnd_gnt_%0d ig/dg/req=%b%b%b want %b%b%b", n,
                     instr_gnt, data_gnt, ram_req, ig, dg, ig | dg);
         end
         checks++;
         if (ig ? ({ram_addr, ram_we, ram_be} !== {iaddr, 1'b0, 4'hF}) :
             dg ? ({ram_addr, ram_we, ram_be, ram_wdata} !==
                   {daddr, dwe, dbe, dwdata}) :
                  ({ram_addr, ram_we, ram_be, ram_wdata} !== 69'h0)) begin
            errors++;
            $display("FAIL rnd_bus_%0d a=%h we=%b be=%h wd=%h", n,
                     ram_addr, ram_we, ram_be, ram_wdata);
         end
         checks++;
         if ({instr_rvalid, instr_rdata, data_rvalid, data_rdata} !==
             {exp_iv, exp_ir, exp_dv, exp_dr}) begin
            errors++;
            $display("FAIL rnd_resp_%0d got %b/%h %b/%h want %b/%h %b/%h", n,
                     instr_rvalid, instr_rdata, data_rvalid, data_rdata,
                     exp_iv, exp_ir, exp_dv, exp_dr);
         end
         commit();
         if (ig) ip = 0;
         if (dg) dp = 0;
         @(posedge clk); #1;
      end
      idle();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 256; i++) begin
         mem[i] = $urandom;
         gold[i] = mem[i];
      end
      mem[16] = 32'h1234_5678; gold[16] = 32'h1234_5678;
      mem[64] = 32'h0;         gold[64] = 32'h0;
      idle();
      model_clear();
      test_reset();
      test_single_instr();
      test_byte_write();
      test_contention();
      test_back_to_back();
      test_midflight_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
